// File: rtl/proc_pkg.sv
// Shared processor definitions: fetch FSM states and fetch-stage constants.
package proc_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

  localparam int unsigned ILEN             = 32;
  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues one imem request per fetch step, and hands the word to decode.
// Optional macro FETCH_ALIGN_CHK_EN: a misaligned redirect target raises fault_o instead of being aligned.
//   state | meaning
//   IDLE  | waiting for fetch_en_i from the sequencer
//   REQ   | imem_req_o high with imem_addr_o, waiting for grant
//   WAIT  | granted, waiting for the single response
//   HOLD  | instruction (or fault) presented to decode
module fetch_unit
  import proc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fetch_en_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            fault_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic            squash_q, squash_d;
  logic            start;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] start_pc;
`ifdef FETCH_ALIGN_CHK_EN
  logic            fault_q, fault_d;

  assign redirect_target = redirect_pc_i;
`else
  assign redirect_target = redirect_pc_i & ~XLEN'(2'b11);
`endif

  // A new request always uses the PC in effect after this cycle's redirect.
  assign start_pc = redirect_i ? redirect_target : pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    squash_d   = squash_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    start      = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    fault_d    = fault_q;
`endif
    if (redirect_i) pc_d = redirect_target;
    case (state_q)
      IDLE: start = fetch_en_i && !redirect_i;
      REQ: begin
        if (redirect_i) squash_d = 1'b1;
        if (imem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          // A redirect coinciding with the response squashes it on the spot.
          if (squash_q || redirect_i) begin
            squash_d = 1'b0;
            start    = 1'b1;
          end else begin
            state_d    = HOLD;
            instr_d    = imem_rdata_i;
            instr_pc_d = pc_q;
            pc_d       = pc_q + XLEN'(PC_STEP);
          end
        end else if (redirect_i) begin
          squash_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_i || instr_ready_i) begin
          state_d = IDLE;
`ifdef FETCH_ALIGN_CHK_EN
          fault_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = REQ;
      addr_d  = start_pc;
`ifdef FETCH_ALIGN_CHK_EN
      if (start_pc[1:0] != 2'b00) begin
        state_d    = HOLD;
        addr_d     = addr_q;
        instr_d    = '0;
        instr_pc_d = start_pc;
        fault_d    = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      squash_q   <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
`ifdef FETCH_ALIGN_CHK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      squash_q   <= squash_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
`ifdef FETCH_ALIGN_CHK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = (state_q == HOLD);
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
`ifdef FETCH_ALIGN_CHK_EN
  assign fault_o       = fault_q;
`else
  assign fault_o       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table vectors, hand-written corner sequences and randomized fetches.
module tb_fetch_unit;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, redirect, gnt, rvalid, ready;
  logic [31:0] redirect_pc, rdata;
  logic        req, valid, fault;
  logic [31:0] addr, instr, instr_pc;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_pc;

  typedef struct {
    bit          do_redir;
    logic [31:0] target;
    int          gnt_dly;
    int          rv_dly;
    int          hold_dly;
    logic [31:0] data;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fetch_en_i    (fetch_en),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .instr_valid_o (valid),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_ready_i (ready),
    .fault_o       (fault)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Architectural PC after a redirect, from the block's rules.
  function automatic logic [31:0] redir_model(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHK_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction

  task automatic redir_idle(input logic [31:0] t);
    redirect = 1'b1;
    redirect_pc = t;
    @(negedge clk);
    redirect = 1'b0;
    chk("redir_idle req", {31'b0, req}, 32'd1 - 32'd1);
    model_pc = redir_model(t);
  endtask

  task automatic do_fetch(input int gd, input int rd, input int hd, input logic [31:0] data,
                          input logic [31:0] exp_pc, input string nm);
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    chk({nm, " req"}, {31'b0, req}, 32'd1);
    chk({nm, " addr"}, addr, exp_pc);
    for (int i = 0; i < gd; i++) begin
      @(negedge clk);
      chk({nm, " addr held"}, addr, exp_pc);
    end
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk({nm, " req drop"}, {31'b0, req}, 32'd0);
    repeat (rd) @(negedge clk);
    rvalid = 1'b1;
    rdata = data;
    @(negedge clk);
    rvalid = 1'b0;
    rdata = $urandom();
    chk({nm, " valid"}, {31'b0, valid}, 32'd1);
    chk({nm, " instr"}, instr, data);
    chk({nm, " instr_pc"}, instr_pc, exp_pc);
    chk({nm, " fault"}, {31'b0, fault}, 32'd0);
    for (int i = 0; i < hd; i++) begin
      @(negedge clk);
      chk({nm, " stall instr"}, instr, data);
      chk({nm, " stall pc"}, instr_pc, exp_pc);
      chk({nm, " stall no req"}, {31'b0, req}, 32'd0);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk({nm, " valid drop"}, {31'b0, valid}, 32'd0);
    model_pc = exp_pc + 32'd4;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0;
    model_pc = 32'h0;

    vecs[0] = '{1'b1, 32'h0000_0040, 1, 2, 1, 32'h1111_1111, 32'h0000_0040};
    vecs[1] = '{1'b0, 32'h0,         0, 0, 0, 32'h2222_2222, 32'h0000_0044};
    vecs[2] = '{1'b1, 32'hFFFF_FFFC, 2, 1, 0, 32'h3333_3333, 32'hFFFF_FFFC};
    vecs[3] = '{1'b0, 32'h0,         0, 1, 2, 32'h4444_4444, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h0,         3, 0, 5, 32'h5555_5555, 32'h0000_0004};
    vecs[5] = '{1'b1, 32'h0000_1000, 0, 3, 0, 32'h6666_6666, 32'h0000_1000};

    // Reset values
    #1;
    chk("rst req", {31'b0, req}, 32'd0);
    chk("rst addr", addr, 32'h0);
    chk("rst valid", {31'b0, valid}, 32'd0);
    chk("rst instr", instr, 32'h0);
    chk("rst instr_pc", instr_pc, 32'h0);
    chk("rst fault", {31'b0, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Best case: fetch_en cycle 0, gnt 1, rvalid 2, valid at 3
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    chk("best req c1", {31'b0, req}, 32'd1);
    chk("best addr", addr, 32'h0);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk("best valid c2", {31'b0, valid}, 32'd0);
    rvalid = 1'b1; rdata = 32'h0000_0093;
    @(negedge clk);
    rvalid = 1'b0;
    chk("best valid c3", {31'b0, valid}, 32'd1);
    chk("best instr", instr, 32'h0000_0093);
    chk("best instr_pc", instr_pc, 32'h0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    model_pc = 32'h4;
    do_fetch(0, 0, 0, 32'hABCD_0001, model_pc, "next pc4");

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].do_redir) redir_idle(vecs[v].target);
      do_fetch(vecs[v].gnt_dly, vecs[v].rv_dly, vecs[v].hold_dly, vecs[v].data,
               vecs[v].exp_pc, $sformatf("vec%0d", v));
    end

    // Redirect during an ungranted request: old address held, response squashed
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    chk("sq req", {31'b0, req}, 32'd1);
    chk("sq addr", addr, model_pc);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    chk("sq addr hold1", addr, 32'h0000_1004);
    @(negedge clk);
    chk("sq addr hold2", addr, 32'h0000_1004);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rvalid = 1'b0;
    chk("sq dropped", {31'b0, valid}, 32'd0);
    chk("sq rereq", {31'b0, req}, 32'd1);
    chk("sq new addr", addr, 32'h0000_0100);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'h0000_0113;
    @(negedge clk);
    rvalid = 1'b0;
    chk("sq valid", {31'b0, valid}, 32'd1);
    chk("sq instr", instr, 32'h0000_0113);
    chk("sq instr_pc", instr_pc, 32'h0000_0100);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    model_pc = 32'h0000_0104;

    // Redirect and ready in the same HOLD cycle
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'h0000_0213;
    @(negedge clk);
    rvalid = 1'b0;
    chk("rr instr_pc", instr_pc, 32'h0000_0104);
    redirect = 1'b1; redirect_pc = 32'h0000_0200; ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0; ready = 1'b0;
    chk("rr valid drop", {31'b0, valid}, 32'd0);
    @(negedge clk);
    chk("rr idle", {31'b0, req}, 32'd0);
    model_pc = 32'h0000_0200;
    do_fetch(1, 0, 0, 32'h0000_0313, model_pc, "rr target");

    // Reset mid-transaction, then a late response is ignored
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst req", {31'b0, req}, 32'd0);
    chk("mrst addr", addr, 32'h0);
    chk("mrst instr_pc", instr_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    rvalid = 1'b0;
    chk("mrst late rvalid", {31'b0, valid}, 32'd0);
    model_pc = 32'h0;
    do_fetch(0, 0, 0, 32'h0000_0413, model_pc, "after mrst");

    // Misaligned redirect target
`ifdef FETCH_ALIGN_CHK_EN
    redir_idle(32'h0000_0102);
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    chk("mis no req", {31'b0, req}, 32'd0);
    chk("mis valid", {31'b0, valid}, 32'd1);
    chk("mis fault", {31'b0, fault}, 32'd1);
    chk("mis instr", instr, 32'h0);
    chk("mis instr_pc", instr_pc, 32'h0000_0102);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("mis valid drop", {31'b0, valid}, 32'd0);
    redir_idle(32'h0000_0100);
    do_fetch(0, 0, 0, 32'h0000_0513, model_pc, "mis recover");
`else
    redir_idle(32'h0000_0102);
    do_fetch(0, 0, 0, 32'h0000_0513, model_pc, "mis aligned");
    chk("mis model", model_pc, 32'h0000_0104);
`endif

    // Randomized fetches against the PC model
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) redir_idle($urandom() & 32'hFFFF_FFFC);
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom(), model_pc, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the multi-cycle processor, sitting directly upstream of decode. On the sequencer's fetch enable (step bit 0), it holds the program counter, issues one request on the instruction-memory request/grant/response interface, and presents the returned word to decode over a valid/ready handshake. Branch and jump redirects from execute/writeback are accepted in any state; any in-flight response is squashed.

## Interface
- `XLEN`, 32: address and PC width.
- `RESET_PC`, 32'h0000_0000: PC value loaded at reset.
- `clk_i` in 1: clock; all logic is on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `fetch_en_i` in 1: fetch-step enable from the sequencer; sampled only in IDLE.
- `redirect_i` in 1: load a new PC, pulse, any state.
- `redirect_pc_i` in XLEN: redirect target.
- `imem_req_o` out 1: memory request.
- `imem_addr_o` out XLEN: request address; held stable while `imem_req_o` is high and ungranted.
- `imem_gnt_i` in 1: request accepted.
- `imem_rvalid_i` in 1: response valid; exactly one per grant, at least one cycle after the grant.
- `imem_rdata_i` in 32: response word.
- `instr_valid_o` out 1: instruction available to decode.
- `instr_o` out 32: fetched instruction.
- `instr_pc_o` out XLEN: PC of `instr_o`.
- `instr_ready_i` in 1: decode accepts.
- `fault_o` out 1: misaligned-fetch fault, qualified by `instr_valid_o`.

## Operation
- **State machine (`fetch_state_t`):**
  - IDLE: `fetch_en_i` → REQ.
  - REQ: `imem_req_o`=1, `imem_addr_o`=pc. `imem_gnt_i` → WAIT.
  - WAIT: `imem_rvalid_i` → HOLD, unless the squash flag is set.
  - HOLD: `instr_valid_o`=1. `instr_ready_i` → IDLE.
- **Capture on an unsquashed response:**
  - `instr_o` ← `imem_rdata_i`.
  - `instr_pc_o` ← pc.
  - pc ← pc + 4, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- **Redirect, which wins over every other event in the same cycle:**
  - pc ← `redirect_pc_i`.
  - In IDLE: stay in IDLE.
  - In REQ: `imem_addr_o` stays unchanged until grant. The squash flag is set, and the granted transaction is discarded when its response arrives.
  - In WAIT: the squash flag is set.
  - In HOLD: drop `instr_valid_o` and go to IDLE, even if `instr_ready_i`=1 in that cycle.
- **Squashed response in WAIT:** clear the squash flag, go to REQ with the new pc, and capture nothing.
- **Repeat redirects:** a second redirect while squash is set only updates pc.
- **Stable outputs:** `instr_o`, `instr_pc_o` and `fault_o` stay stable while `instr_valid_o`=1 and not accepted.

## Timing
- **Reset values:**
  - state IDLE, pc=`RESET_PC`, squash=0.
  - `imem_req_o`=0, `imem_addr_o`=`RESET_PC`.
  - `instr_valid_o`=0, `instr_o`=0, `instr_pc_o`=0, `fault_o`=0.
- **Reset mid-transaction:** a reset asserted mid-transaction abandons it. After reset, any late `imem_rvalid_i` in IDLE/REQ is ignored.
- **Registered outputs:** all outputs are registered.
- **Best-case latency:** with `fetch_en_i` at cycle 0, grant at 1 and rvalid at 2:
  - `imem_req_o` rises at cycle 1.
  - `instr_valid_o` rises at cycle 3.
- **Back-to-back:** `fetch_en_i` on the cycle after acceptance starts the next fetch; there is no overlap of requests.
- **Grant wait:** there is no timeout on `imem_gnt_i`/`imem_rvalid_i`.

## Configuration
- Macro: `FETCH_ALIGN_CHK_EN`.
- **Defined:**
  - A redirect target with bits [1:0]≠0 is loaded as-is.
  - The next REQ issues no memory request; the FSM goes straight to HOLD with `fault_o`=1, `instr_o`=0 and `instr_pc_o`=the bad PC.
  - Acceptance returns to IDLE with pc unchanged; the next redirect clears the fault.
- **Undefined:** redirect bits [1:0] are forced to 0 on load, and `fault_o` is tied 0.

## Structure
- **`proc_pkg` (shared):**
  - `fetch_state_t` enum (IDLE, REQ, WAIT, HOLD).
  - `ILEN`=32.
  - `PC_STEP`=4.
  - Default `RESET_PC`.
- **Sub-modules:** none; a single module. The PC register and next-PC mux stay inline.

## Test plan
- Reset, then `fetch_en_i` at cycle 0, grant at 1, rvalid at 2 with 32'h0000_0093 → `instr_valid_o` at cycle 3 with `instr_pc_o`=0; the next fetch uses address 4.
- Grant delayed 3 cycles while `redirect_i` pulses to 32'h100 → `imem_addr_o` stays 0 until grant. The response is dropped, a new request goes to 32'h100, and `instr_pc_o`=32'h100.
- Decode holds `instr_ready_i`=0 for 5 cycles → `instr_o`/`instr_pc_o` stay constant, and there is no new request.
- `redirect_i` and `instr_ready_i` in the same HOLD cycle → the instruction is not delivered, the FSM is in IDLE, and pc equals the target.
- pc=32'hFFFF_FFFC fetch → next pc=0.
- With `FETCH_ALIGN_CHK_EN`, redirect to 32'h102 → no `imem_req_o`, `fault_o`=1, `instr_pc_o`=32'h102. Without the macro, the fetch goes to address 32'h100.
